// File: rtl/mod_add_if.sv
// Request/response bundle for the shared modular adder: two requester channels
// on the request side, one shared result bus on the response side.
interface mod_add_if #(parameter int DW = 15) ();
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_a0, req_b0;
  logic [DW-1:0] req_a1, req_b1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mod_add_arbiter.sv
// Two-channel round-robin front end for a single (a+b) mod P adder.
// Two registered stages; a stalled response freezes the whole pipe.
module mod_add_arbiter #(
  parameter int P  = 12289,
  parameter int DW = 15
) (
  input logic     clk,
  input logic     rst_n,
  mod_add_if.slave bus
);
  localparam int STAGES = 2;
  localparam logic [DW-1:0] P_W   = DW'(P);
  localparam logic [DW-1:0] NEG_P = ~P_W + DW'(1);

  typedef struct packed {
    logic          id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } s1_t;

  logic [STAGES:1]      vld_pipe;
  s1_t                  s1;
  logic                 s2_id;
  logic [DW-1:0]        s2_data;
  logic                 rr_last;

  logic [1:0]           grant, hs;
  logic                 hs_any, hs_id, stall;
  logic [1:0][DW-1:0]   ops_a, ops_b;
  logic [DW-1:0]        sum_raw, sum_red, sum_mod;

  assign ops_a = {bus.req_a1, bus.req_a0};
  assign ops_b = {bus.req_b1, bus.req_b0};

  assign stall = vld_pipe[2] & ~bus.rsp_ready[s2_id];

  always_comb begin
    grant = '0;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // rst_n gating keeps req_ready low for the whole reset window, not just after an edge
  assign bus.req_ready = grant & {2{~stall & rst_n}};
  assign hs     = bus.req_valid & bus.req_ready;
  assign hs_any = |hs;
  assign hs_id  = hs[1];

  // Reduction by adding the negated modulus; operands < P so one subtract suffices
  assign sum_raw = s1.a + s1.b;
  assign sum_red = sum_raw + NEG_P;
  assign sum_mod = (sum_raw >= P_W) ? sum_red : sum_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2_id    <= 1'b0;
      s2_data  <= '0;
      rr_last  <= 1'b1;
    end else if (!stall) begin
      vld_pipe[1] <= hs_any;
      vld_pipe[2] <= vld_pipe[1];
      s2_id       <= s1.id;
      s2_data     <= sum_mod;
      if (hs_any) begin
        s1.id   <= hs_id;
        s1.a    <= ops_a[hs_id];
        s1.b    <= ops_b[hs_id];
        rr_last <= hs_id;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign bus.rsp_valid[i] = vld_pipe[2] & (s2_id == 1'(i));
  end

  assign bus.rsp_data = s2_data;
  assign bus.busy     = |vld_pipe;
endmodule

// File: tb/tb_mod_add_arbiter.sv
// Self-checking bench for mod_add_arbiter: directed scenarios plus a random
// run, with per-channel expected-result queues filled at request handshake.
module tb_mod_add_arbiter;
  localparam int P  = 12289;
  localparam int DW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_add_if #(.DW(DW)) bus ();
  mod_add_arbiter #(.P(P), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];

  task automatic drive(input logic [1:0] v, input int a0, input int b0,
                       input int a1, input int b1, input logic [1:0] rr);
    bus.req_valid = v;
    bus.req_a0 = DW'(a0); bus.req_b0 = DW'(b0);
    bus.req_a1 = DW'(a1); bus.req_b1 = DW'(b1);
    bus.rsp_ready = rr;
  endtask

  // Model: record (a+b)%P for whichever channel handshakes this cycle
  task automatic push_hs();
    if (bus.req_valid[0] && bus.req_ready[0])
      sb0.push_back(DW'((int'(bus.req_a0) + int'(bus.req_b0)) % P));
    if (bus.req_valid[1] && bus.req_ready[1])
      sb1.push_back(DW'((int'(bus.req_a1) + int'(bus.req_b1)) % P));
  endtask

  task automatic do_reset();
    drive(2'b00, 0, 0, 0, 0, 2'b11);
    rst_n = 1'b0;
    sb0.delete(); sb1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(2'b11, 1, 2, 3, 4, 2'b11);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%0d exp=0", bus.rsp_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    drive(2'b00, 0, 0, 0, 0, 2'b11);
    rst_n = 1'b1;
  endtask

  task automatic test_bound();
    @(negedge clk); drive(2'b01, 12288, 12288, 0, 0, 2'b11); #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL bound_req_ready got=%b exp=01", bus.req_ready); end
    @(negedge clk); drive(2'b00, 0, 0, 0, 0, 2'b11); #1;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bound_latency got=%b exp=00", bus.rsp_valid); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bound_busy got=%b exp=1", bus.busy); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL bound_rsp_valid got=%b exp=01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== DW'(12287)) begin n_fail++; $display("FAIL bound_rsp_data got=%0d exp=12287", bus.rsp_data); end
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bound_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_zero();
    @(negedge clk); drive(2'b10, 0, 0, 0, 0, 2'b11); #1;
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL zero_req_ready1 got=%b exp=10", bus.req_ready); end
    @(negedge clk); drive(2'b01, 12288, 1, 0, 0, 2'b11); #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL zero_req_ready0 got=%b exp=01", bus.req_ready); end
    @(negedge clk); drive(2'b00, 0, 0, 0, 0, 2'b11); #1;
    n_checks++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL zero_rsp_valid1 got=%b exp=10", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL zero_rsp_data1 got=%0d exp=0", bus.rsp_data); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL zero_rsp_valid0 got=%b exp=01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL wrap_rsp_data0 got=%0d exp=0", bus.rsp_data); end
    @(negedge clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy, exp_vld;
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) drive(2'b11, $urandom_range(0, P-1), $urandom_range(0, P-1),
                       $urandom_range(0, P-1), $urandom_range(0, P-1), 2'b11);
      else       drive(2'b00, 0, 0, 0, 0, 2'b11);
      #1;
      exp_rdy = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      exp_vld = (i < 2) ? 2'b00 : (((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_grant c%0d got=%b exp=%b", i, bus.req_ready, exp_rdy); end
      n_checks++; if (bus.rsp_valid !== exp_vld) begin n_fail++; $display("FAIL contention_order c%0d got=%b exp=%b", i, bus.rsp_valid, exp_vld); end
      if (bus.rsp_valid[0] && sb0.size() > 0) begin
        e = sb0.pop_front();
        n_checks++; if (bus.rsp_data !== e) begin n_fail++; $display("FAIL contention_data0 c%0d got=%0d exp=%0d", i, bus.rsp_data, e); end
      end
      if (bus.rsp_valid[1] && sb1.size() > 0) begin
        e = sb1.pop_front();
        n_checks++; if (bus.rsp_data !== e) begin n_fail++; $display("FAIL contention_data1 c%0d got=%0d exp=%0d", i, bus.rsp_data, e); end
      end
      push_hs();
    end
    n_checks++; if (sb0.size() + sb1.size() != 0) begin n_fail++; $display("FAIL contention_leftover got=%0d exp=0", sb0.size() + sb1.size()); end
  endtask

  task automatic test_backpressure();
    logic [1:0] vt[9]  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] rt[9]  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] er[9]  = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] ev[9]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    logic [DW-1:0] held, e;
    held = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vt[i], 9000, 5000, 100 + i, 7000, rt[i]);
      #1;
      n_checks++; if (bus.req_ready !== er[i]) begin n_fail++; $display("FAIL bp_req_ready c%0d got=%b exp=%b", i, bus.req_ready, er[i]); end
      n_checks++; if (bus.rsp_valid !== ev[i]) begin n_fail++; $display("FAIL bp_rsp_valid c%0d got=%b exp=%b", i, bus.rsp_valid, ev[i]); end
      if (i == 2) held = bus.rsp_data;
      if (i == 3 || i == 4) begin
        n_checks++; if (bus.rsp_data !== held) begin n_fail++; $display("FAIL bp_hold c%0d got=%0d exp=%0d", i, bus.rsp_data, held); end
      end
      if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
        n_checks++;
        if (sb0.size() == 0) begin n_fail++; $display("FAIL bp_spurious0 c%0d got=1 exp=0", i); end
        else begin e = sb0.pop_front(); if (bus.rsp_data !== e) begin n_fail++; $display("FAIL bp_data0 c%0d got=%0d exp=%0d", i, bus.rsp_data, e); end end
      end
      if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
        n_checks++;
        if (sb1.size() == 0) begin n_fail++; $display("FAIL bp_spurious1 c%0d got=1 exp=0", i); end
        else begin e = sb1.pop_front(); if (bus.rsp_data !== e) begin n_fail++; $display("FAIL bp_data1 c%0d got=%0d exp=%0d", i, bus.rsp_data, e); end end
      end
      push_hs();
    end
    n_checks++; if (sb0.size() + sb1.size() != 0) begin n_fail++; $display("FAIL bp_lost got=%0d exp=0", sb0.size() + sb1.size()); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); drive(2'b01, 100, 200, 0, 0, 2'b11);
    @(negedge clk); drive(2'b10, 0, 0, 300, 400, 2'b11);
    @(negedge clk); drive(2'b11, 1, 1, 1, 1, 2'b11); #1;
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL mid_pre_rsp got=%b exp=01", bus.rsp_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rsp_valid got=%b exp=00", bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_req_ready got=%b exp=00", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    sb0.delete(); sb1.delete();
    @(negedge clk); rst_n = 1'b1; drive(2'b00, 0, 0, 0, 0, 2'b11);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_stale c%0d got=%b exp=00", i, bus.rsp_valid); end
    end
    drive(2'b10, 0, 0, 5, 7, 2'b11); #1;
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL mid_after_ready got=%b exp=10", bus.req_ready); end
    @(negedge clk); drive(2'b00, 0, 0, 0, 0, 2'b11);
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL mid_after_valid got=%b exp=10", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== DW'(12)) begin n_fail++; $display("FAIL mid_after_data got=%0d exp=12", bus.rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int hs_cnt, cyc;
    logic [DW-1:0] e;
    hs_cnt = 0; cyc = 0;
    while (hs_cnt < 1000 && cyc < 5000) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), $urandom_range(0, P-1), $urandom_range(0, P-1),
            $urandom_range(0, P-1), $urandom_range(0, P-1), 2'($urandom_range(0, 3)));
      #1;
      if (bus.rsp_valid == 2'b11) begin n_checks++; n_fail++; $display("FAIL rand_onehot got=11 exp=onehot"); end
      if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
        n_checks++;
        if (sb0.size() == 0) begin n_fail++; $display("FAIL rand_spurious0 cyc=%0d got=1 exp=0", cyc); end
        else begin e = sb0.pop_front(); if (bus.rsp_data !== e) begin n_fail++; $display("FAIL rand_data0 cyc=%0d got=%0d exp=%0d", cyc, bus.rsp_data, e); end end
      end
      if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
        n_checks++;
        if (sb1.size() == 0) begin n_fail++; $display("FAIL rand_spurious1 cyc=%0d got=1 exp=0", cyc); end
        else begin e = sb1.pop_front(); if (bus.rsp_data !== e) begin n_fail++; $display("FAIL rand_data1 cyc=%0d got=%0d exp=%0d", cyc, bus.rsp_data, e); end end
      end
      if (|(bus.req_valid & bus.req_ready)) hs_cnt++;
      push_hs();
      cyc++;
    end
    n_checks++; if (hs_cnt < 1000) begin n_fail++; $display("FAIL rand_budget got=%0d exp=1000", hs_cnt); end
    for (int i = 0; i < 20 && (sb0.size() + sb1.size()) > 0; i++) begin
      @(negedge clk); drive(2'b00, 0, 0, 0, 0, 2'b11); #1;
      if (bus.rsp_valid[0] && sb0.size() > 0) begin
        e = sb0.pop_front();
        n_checks++; if (bus.rsp_data !== e) begin n_fail++; $display("FAIL rand_drain0 got=%0d exp=%0d", bus.rsp_data, e); end
      end
      if (bus.rsp_valid[1] && sb1.size() > 0) begin
        e = sb1.pop_front();
        n_checks++; if (bus.rsp_data !== e) begin n_fail++; $display("FAIL rand_drain1 got=%0d exp=%0d", bus.rsp_data, e); end
      end
    end
    @(negedge clk); #1;
    n_checks++; if (sb0.size() + sb1.size() != 0) begin n_fail++; $display("FAIL rand_lost got=%0d exp=0", sb0.size() + sb1.size()); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    drive(2'b00, 0, 0, 0, 0, 2'b11);
    test_reset();
    test_bound();
    test_zero();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
